// File: rtl/fem_cmd_pkg.sv
// Shared types and constants for the fiber-emulator command sequencer.
// Build option: FEM_CMD_ERRCNT_EN (see fem_cmd_sequencer).
package fem_cmd_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } fem_state_t;

    localparam logic [7:0] SYNC_WORD     = 8'hA5;
    localparam logic [7:0] CMD_L1A       = 8'h11;
    localparam logic [7:0] CMD_L1A_MATCH = 8'h12;
    localparam logic [7:0] CMD_RESYNC    = 8'h21;
    localparam logic [7:0] CMD_INJPLS    = 8'h31;
    localparam logic [7:0] CMD_EXTPLS    = 8'h32;

    // Strobe vector bit positions.
    localparam int unsigned STB_L1A    = 0;
    localparam int unsigned STB_MATCH  = 1;
    localparam int unsigned STB_RESYNC = 2;
    localparam int unsigned STB_INJPLS = 3;
    localparam int unsigned STB_EXTPLS = 4;

    // Returns the strobe set for a frame; all-zero means not a command.
    function automatic logic [4:0] fem_cmd_decode(input logic [7:0] frame);
        logic [4:0] bits;
        bits = '0;
        case (frame)
            CMD_L1A:       bits[STB_L1A] = 1'b1;
            CMD_L1A_MATCH: begin
                bits[STB_L1A]   = 1'b1;
                bits[STB_MATCH] = 1'b1;
            end
            CMD_RESYNC:    bits[STB_RESYNC] = 1'b1;
            CMD_INJPLS:    bits[STB_INJPLS] = 1'b1;
            CMD_EXTPLS:    bits[STB_EXTPLS] = 1'b1;
            default:       bits = '0;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/fem_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module fem_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fem_cmd_sequencer.sv
// Frame alignment and command decode for the fiber-emulator receive stream.
// Build option: define FEM_CMD_ERRCNT_EN to implement the ERR_CNT counter.
module fem_cmd_sequencer
    import fem_cmd_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned PULSE_LEN  = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX_DAT,
    input  logic       SIGDET,
    input  logic       FIBER_DET,
    output logic       L1A,
    output logic       L1A_MATCH,
    output logic       RESYNC,
    output logic       INJPLS,
    output logic       EXTPLS,
    output logic       LOCKED,
    output logic [7:0] ERR_CNT
);

    localparam logic [3:0] LOCK_N       = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N     = 4'(UNLOCK_CNT);
    localparam logic [2:0] PULSE_RELOAD = 3'(PULSE_LEN - 1);

    fem_state_t state, state_nxt;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] good_cnt, good_nxt;
    logic [3:0] bad_cnt, bad_nxt;
    logic [4:0] cmd_bits;
    logic [4:0] strb;
    logic [2:0] stretch;
    logic       sigdet_s, fiber_s, link_ok;
    logic       boundary, is_sync, is_cmd;
    logic       bit_zero, start;

    fem_sync2 u_sync_sigdet (.clk(CLK), .rst_n(RST_N), .d(SIGDET),    .q(sigdet_s));
    fem_sync2 u_sync_fiber  (.clk(CLK), .rst_n(RST_N), .d(FIBER_DET), .q(fiber_s));

    assign link_ok  = sigdet_s & fiber_s;
    assign boundary = (bit_cnt == 3'd7);
    assign is_sync  = (sr == SYNC_WORD);
    assign cmd_bits = fem_cmd_decode(sr);
    assign is_cmd   = |cmd_bits;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_HUNT;
            sr       <= '0;
            bit_cnt  <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            sr       <= {sr[6:0], RX_DAT};
            bit_cnt  <= bit_zero ? 3'd0 : bit_cnt + 3'd1;
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        bit_zero  = 1'b0;
        start     = 1'b0;
        if (!link_ok) begin
            state_nxt = ST_HUNT;
            good_nxt  = '0;
            bad_nxt   = '0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (is_sync) begin
                        bit_zero  = 1'b1;
                        good_nxt  = 4'd1;
                        state_nxt = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (boundary) begin
                        if (is_sync) begin
                            good_nxt = good_cnt + 4'd1;
                            if (good_cnt + 4'd1 >= LOCK_N) begin
                                state_nxt = ST_LOCKED;
                            end
                        end else begin
                            good_nxt  = '0;
                            state_nxt = ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        if (is_sync || is_cmd) begin
                            bad_nxt = '0;
                            start   = is_cmd;
                        end else if (bad_cnt + 4'd1 >= UNLOCK_N) begin
                            bad_nxt   = '0;
                            state_nxt = ST_HUNT;
                        end else begin
                            bad_nxt = bad_cnt + 4'd1;
                        end
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    // Frames are 8 cycles apart and PULSE_LEN <= 8, so a reload never cuts a live strobe short.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            strb    <= '0;
            stretch <= '0;
        end else if (state_nxt != ST_LOCKED) begin
            strb    <= '0;
            stretch <= '0;
        end else if (start) begin
            strb    <= cmd_bits;
            stretch <= PULSE_RELOAD;
        end else if (stretch != 3'd0) begin
            stretch <= stretch - 3'd1;
        end else begin
            strb <= '0;
        end
    end

    assign L1A       = strb[STB_L1A];
    assign L1A_MATCH = strb[STB_MATCH];
    assign RESYNC    = strb[STB_RESYNC];
    assign INJPLS    = strb[STB_INJPLS];
    assign EXTPLS    = strb[STB_EXTPLS];
    assign LOCKED    = (state == ST_LOCKED);

`ifdef FEM_CMD_ERRCNT_EN
    logic [7:0] err_cnt;
    logic       err_inc, err_clr;

    assign err_inc = link_ok && (state == ST_LOCKED) && boundary && !is_sync && !is_cmd;
    assign err_clr = link_ok && (state == ST_LOCKED) && boundary && cmd_bits[STB_RESYNC];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err_inc && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign ERR_CNT = err_cnt;
`else
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_fem_cmd_sequencer.sv
// Bench for fem_cmd_sequencer: three parameterisations share one stimulus stream
// and are checked every cycle against a frame-level model of the receive link.
module tb_fem_cmd_sequencer;

    localparam int MAXN = 16384;
    localparam int unsigned P_LOCK[3] = '{4, 4, 5};
    localparam int unsigned P_UNL[3]  = '{4, 4, 15};
    localparam int unsigned P_PUL[3]  = '{1, 8, 3};
    localparam int M_SEARCH  = 0;
    localparam int M_CONFIRM = 1;
    localparam int M_ALIGNED = 2;
`ifdef FEM_CMD_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic RX_DAT = 1'b0;
    logic SIGDET = 1'b0;
    logic FIBER_DET = 1'b0;
    logic [2:0][4:0] o_str;
    logic [2:0]      o_lock;
    logic [2:0][7:0] o_err;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fem_cmd_sequencer #(
            .LOCK_CNT  (P_LOCK[g]),
            .UNLOCK_CNT(P_UNL[g]),
            .PULSE_LEN (P_PUL[g])
        ) u_dut (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .RX_DAT   (RX_DAT),
            .SIGDET   (SIGDET),
            .FIBER_DET(FIBER_DET),
            .L1A      (o_str[g][0]),
            .L1A_MATCH(o_str[g][1]),
            .RESYNC   (o_str[g][2]),
            .INJPLS   (o_str[g][3]),
            .EXTPLS   (o_str[g][4]),
            .LOCKED   (o_lock[g]),
            .ERR_CNT  (o_err[g])
        );
    end

    bit         rx_a [MAXN];
    bit         sig_a[MAXN];
    bit         fib_a[MAXN];
    logic [13:0] exp_v[3][MAXN];   // {err[7:0], locked, strobes[4:0]} after edge k
    int len = 0;
    int chk = 0;
    int errs = 0;
    bit run = 1'b0;
    bit done = 1'b0;

    function automatic logic [4:0] dec(input logic [7:0] b);
        case (b)
            8'h11:   return 5'b00001;
            8'h12:   return 5'b00011;
            8'h21:   return 5'b00100;
            8'h31:   return 5'b01000;
            8'h32:   return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [7:0] rand_invalid();
        logic [7:0] b;
        do b = 8'($urandom); while (dec(b) != 5'b0 || b == 8'hA5);
        return b;
    endfunction

    task automatic push_bit(input bit b);
        if (len < MAXN) begin
            rx_a[len]  = b;
            sig_a[len] = 1'b1;
            fib_a[len] = 1'b1;
            len++;
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
    endtask

    task automatic push_syncs(input int n);
        for (int i = 0; i < n; i++) push_frame(8'hA5);
    endtask

    // Frame-level view: the link is watched cycle by cycle only to find the
    // first aligned sync and to honour link loss; afterwards frames are taken
    // every 8 bits from the alignment point.
    task automatic run_model(input int g);
        int mode, good, bad, err, nb, s_end, idx;
        logic [4:0] bits, d;
        logic [7:0] w;
        bit lk;
        mode = M_SEARCH; good = 0; bad = 0; err = 0; nb = 0; s_end = -1; bits = '0;
        exp_v[g][0] = '0;
        for (int k = 0; k < len - 1; k++) begin
            lk = (k >= 1) ? (sig_a[k-1] & fib_a[k-1]) : 1'b0;
            w = '0;
            for (int b = 0; b < 8; b++) begin
                idx = k - 7 + b;
                w = {w[6:0], (idx >= 0) ? rx_a[idx] : 1'b0};
            end
            d = dec(w);
            if (!lk) begin
                mode = M_SEARCH; good = 0; bad = 0; s_end = -1;
            end else if (mode == M_SEARCH) begin
                if (w == 8'hA5) begin
                    mode = M_CONFIRM; good = 1; nb = k + 8;
                end
            end else if (k == nb) begin
                nb = k + 8;
                if (mode == M_CONFIRM) begin
                    if (w == 8'hA5) begin
                        good++;
                        if (good >= int'(P_LOCK[g])) mode = M_ALIGNED;
                    end else begin
                        mode = M_SEARCH;
                    end
                end else if (w == 8'hA5 || d != 5'b0) begin
                    bad = 0;
                    if (d != 5'b0) begin
                        bits = d;
                        s_end = k + int'(P_PUL[g]);
                        if (d[2]) err = 0;
                    end
                end else begin
                    bad++;
                    if (err < 255) err++;
                    if (bad >= int'(P_UNL[g])) begin
                        mode = M_SEARCH; bad = 0; s_end = -1;
                    end
                end
            end
            exp_v[g][k+1] = {(ERR_EN ? 8'(err) : 8'h00), (mode == M_ALIGNED),
                             ((k + 1 <= s_end) ? bits : 5'b0)};
        end
    endtask

    task automatic pin(input string nm, input int got, input int want);
        chk++;
        if (got != want) begin
            errs++;
            $display("FAIL pin %s: model=%0d required=%0d", nm, got, want);
        end
    endtask

    // Per-cycle comparison of every DUT against the model.
    initial begin
        logic [13:0] act;
        wait (run);
        for (int k = 0; k < len; k++) begin
            @(posedge CLK);
            #1;
            for (int g = 0; g < 3; g++) begin
                act = {o_err[g], o_lock[g], o_str[g]};
                chk++;
                if (act !== exp_v[g][k]) begin
                    errs++;
                    $display("FAIL cycle %0d dut%0d: got locked=%b str=%b err=%h, want locked=%b str=%b err=%h",
                             k, g, act[5], act[4:0], act[13:6],
                             exp_v[g][k][5], exp_v[g][k][4:0], exp_v[g][k][13:6]);
                end
            end
        end
        done = 1'b1;
    end

    initial begin
        #(MAXN * 30);
        $display("FAIL watchdog: run did not complete, errors so far %0d", errs);
        $fatal(1, "timeout");
    end

    initial begin
        int t12, t31, t11a, t_z, t_r, t_s, t_f, r, n;
        // Lock at bit offset 3, then the directed command/error sequence.
        for (int i = 0; i < 3; i++) push_bit(1'b0);
        push_syncs(6);
        push_frame(8'h12); t12 = len - 1;
        push_frame(8'hA5);
        push_frame(8'h31); t31 = len - 1;
        push_frame(8'h32);
        push_syncs(2);
        push_frame(8'h11); t11a = len - 1;
        push_frame(8'h11);
        push_syncs(2);
        for (int i = 0; i < 4; i++) push_frame(8'h00);
        t_z = len - 1;
        push_frame(8'h21); t_r = len - 1;
        push_syncs(6);
        push_frame(8'h11); t_s = len - 1;
        push_syncs(3);
        for (int i = t_s + 3; i < t_s + 23; i++) sig_a[i] = 1'b0;
        push_syncs(6);
        for (int i = 0; i < 300; i++) begin
            push_frame(rand_invalid());
            push_frame(8'hA5);
        end
        push_frame(8'h21); t_f = len - 1;
        // Randomised traffic with slips and link glitches.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) push_frame(8'hA5);
            else if (r < 60) begin
                case ($urandom_range(0, 4))
                    0: push_frame(8'h11);
                    1: push_frame(8'h12);
                    2: push_frame(8'h21);
                    3: push_frame(8'h31);
                    default: push_frame(8'h32);
                endcase
            end else if (r < 75) push_frame(rand_invalid());
            else if (r < 82) begin
                n = $urandom_range(1, 7);
                for (int j = 0; j < n; j++) push_bit(1'($urandom));
            end else if (r < 88) begin
                n = $urandom_range(1, 12);
                for (int j = 0; j < n; j++) begin
                    push_bit(1'($urandom));
                    if (r < 85) sig_a[len-1] = 1'b0;
                    else fib_a[len-1] = 1'b0;
                end
            end else push_syncs($urandom_range(2, 6));
        end
        push_syncs(3);

        for (int g = 0; g < 3; g++) run_model(g);

        // Hand-derived anchors for the model.
        pin("lock4_before", int'(exp_v[0][34][5]), 0);
        pin("lock4_after", int'(exp_v[0][35][5]), 1);
        pin("lock4_no_strobe", int'(exp_v[0][35][4:0]), 0);
        pin("lock5_before", int'(exp_v[2][42][5]), 0);
        pin("lock5_after", int'(exp_v[2][43][5]), 1);
        pin("l1a_match_on", int'(exp_v[0][t12+1][4:0]), 3);
        pin("l1a_match_off", int'(exp_v[0][t12+2][4:0]), 0);
        pin("injpls", int'(exp_v[0][t31+1][4:0]), 8);
        pin("extpls", int'(exp_v[0][t31+9][4:0]), 16);
        for (int j = 1; j <= 16; j++) pin("l1a_stretch", int'(exp_v[1][t11a+j][0]), 1);
        pin("l1a_stretch_end", int'(exp_v[1][t11a+17][0]), 0);
        pin("unlock_before", int'(exp_v[0][t_z][5]), 1);
        pin("unlock_after", int'(exp_v[0][t_z+1][5]), 0);
        pin("unlock_err", int'(exp_v[0][t_z+1][13:6]), ERR_EN ? 4 : 0);
        pin("resync_hunting", int'(exp_v[0][t_r+1][4:0]), 0);
        pin("resync_locked", int'(exp_v[2][t_r+1][4:0]), 4);
        pin("resync_err_clr", int'(exp_v[2][t_r+1][13:6]), 0);
        pin("sigdrop_lock_hold", int'(exp_v[1][t_s+4][5]), 1);
        pin("sigdrop_lock_gone", int'(exp_v[1][t_s+5][5]), 0);
        pin("sigdrop_l1a_hold", int'(exp_v[1][t_s+4][0]), 1);
        pin("sigdrop_l1a_gone", int'(exp_v[1][t_s+5][0]), 0);
        pin("sat_err", int'(exp_v[2][t_f][13:6]), ERR_EN ? 255 : 0);
        pin("sat_resync", int'(exp_v[2][t_f+1][4:0]), 4);
        pin("sat_clear", int'(exp_v[2][t_f+1][13:6]), 0);

        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk++;
            if ({o_err[g], o_lock[g], o_str[g]} !== 14'h0) begin
                errs++;
                $display("FAIL reset dut%0d: got locked=%b str=%b err=%h, want all zero",
                         g, o_lock[g], o_str[g], o_err[g]);
            end
        end
        @(negedge CLK);
        RX_DAT = rx_a[0]; SIGDET = sig_a[0]; FIBER_DET = fib_a[0];
        RST_N = 1'b1;
        run = 1'b1;
        for (int k = 1; k < len; k++) begin
            @(negedge CLK);
            RX_DAT = rx_a[k]; SIGDET = sig_a[k]; FIBER_DET = fib_a[k];
        end
        wait (done);
        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
